// File: rtl/coeff_loader.sv
// Serial-to-parallel coefficient loader: deserializes MSB-first 16-bit words
// framed by a word-start strobe and drives the coefficient memory write port.
module coeff_loader #(
    parameter int NUM_COEFF = 512,
    parameter int WORD_W    = 16
) (
    input  logic              Sclk,
    input  logic              Reset_n,
    input  logic              load_start,
    input  logic              Frame,
    input  logic              InputL,
    output logic [WORD_W-1:0] in_data,
    output logic [8:0]        coeffwrite,
    output logic              write_enable,
    output logic              busy,
    output logic              load_done,
    output logic              frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        SHIFT,
        WRITE,
        DONE
    } state_t;

    localparam int              CNT_W     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [8:0]       LAST_ADDR = 9'(NUM_COEFF - 1);

    state_t            state, state_nxt;
    logic [WORD_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [WORD_W-1:0] in_data_nxt;
    logic [8:0]        addr_nxt;
    logic              we_nxt, busy_nxt, done_nxt, err_nxt;

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            in_data      <= '0;
            coeffwrite   <= '0;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            load_done    <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            bit_cnt      <= bit_cnt_nxt;
            in_data      <= in_data_nxt;
            coeffwrite   <= addr_nxt;
            write_enable <= we_nxt;
            busy         <= busy_nxt;
            load_done    <= done_nxt;
            frame_err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        in_data_nxt = in_data;
        addr_nxt    = coeffwrite;
        we_nxt      = 1'b0;
        busy_nxt    = busy;
        done_nxt    = load_done;
        err_nxt     = frame_err;

        if (load_start) begin
            state_nxt   = WAIT_FRAME;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
            addr_nxt    = '0;
            busy_nxt    = 1'b1;
            done_nxt    = 1'b0;
            err_nxt     = 1'b0;
        end else begin
            case (state)
                WAIT_FRAME: begin
                    if (Frame) begin
                        shreg_nxt   = {{(WORD_W-1){1'b0}}, InputL};
                        bit_cnt_nxt = ONE;
                        state_nxt   = SHIFT;
                    end
                end
                SHIFT: begin
                    // The word is latched one edge after its LSB so the write
                    // strobe comes straight from a register.
                    if (bit_cnt == FULL) begin
                        in_data_nxt = shreg;
                        we_nxt      = 1'b1;
                        state_nxt   = WRITE;
                    end else if (Frame) begin
                        err_nxt     = 1'b1;
                        shreg_nxt   = {{(WORD_W-1){1'b0}}, InputL};
                        bit_cnt_nxt = ONE;
                    end else begin
                        shreg_nxt   = {shreg[WORD_W-2:0], InputL};
                        bit_cnt_nxt = bit_cnt + ONE;
                    end
                end
                WRITE: begin
                    if (coeffwrite == LAST_ADDR) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        addr_nxt = coeffwrite + 9'd1;
                        if (Frame) begin
                            shreg_nxt   = {{(WORD_W-1){1'b0}}, InputL};
                            bit_cnt_nxt = ONE;
                            state_nxt   = SHIFT;
                        end else begin
                            bit_cnt_nxt = '0;
                            state_nxt   = WAIT_FRAME;
                        end
                    end
                end
                IDLE, DONE: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
